mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Sits directly downstream of the pipeline core.
- Merges the core's instruction-fetch port (ibus) and data port (dbus) into one single-beat memory port (cbus) toward the cache/memory subsystem.
- Performs the addr_ok/data_ok handshakes the core depends on. Serialises accesses: one outstanding transaction at a time, dbus normally preferred.

Parameters:
- ROUND_ROBIN, 0, 0 = dbus always wins ties; 1 = the master granted last loses a tie.
- RESET_GRANT_D, 1, initial value of the last-granted flag (1 = dbus).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  ibus request
- i_req_addr  in  64  fetch address, 4-byte aligned
- i_resp_addr_ok  out  1  ibus request accepted (pulse)
- i_resp_data_ok  out  1  ibus data valid (pulse)
- i_resp_data  out  32  fetched instruction
- d_req_valid  in  1  dbus request
- d_req_addr  in  64  data address
- d_req_size  in  3  log2 bytes (0..3)
- d_req_strobe  in  8  byte write enables; 0 = read
- d_req_data  in  64  write data, lane-aligned
- d_resp_addr_ok  out  1  dbus request accepted (pulse)
- d_resp_data_ok  out  1  dbus data valid (pulse)
- d_resp_data  out  64  read data, full 64-bit line-aligned word
- c_req_valid  out  1  memory request
- c_req_is_write  out  1  1 = write
- c_req_size  out  3  log2 bytes
- c_req_addr  out  64  address
- c_req_strobe  out  8  byte enables
- c_req_data  out  64  write data
- c_resp_ready  in  1  response beat valid
- c_resp_last  in  1  final beat marker
- c_resp_data  in  64  read data

Behaviour:
- FSM states: IDLE, BUSY, RESP. Registers: owner (I/D), last_grant, latched request fields, latched response data.
- Reset: state=IDLE, c_req_valid=0, all addr_ok/data_ok=0, response data regs=0, c_req_* fields=0, last_grant=RESET_GRANT_D.
- Reset mid-transaction forces IDLE immediately. A later c_resp_ready is ignored (only sampled in BUSY).
- IDLE grant (combinational, gated by !reset):
  - Only one valid: that master is granted.
  - Both valid, ROUND_ROBIN=0: dbus is granted.
  - Both valid, ROUND_ROBIN=1: the master not equal to last_grant is granted.
- Grant cycle T:
  - The granted master's addr_ok=1 for exactly that cycle; the other master's addr_ok=0.
  - At the clock edge, latch the request, set owner and last_grant, go to BUSY.
- ibus latched request: is_write=0, size=3'b010, strobe=0, data=0, addr=i_req_addr.
- dbus latched request: is_write=(d_req_strobe!=0), plus size/addr/strobe/data copied unchanged.
- BUSY:
  - c_req_valid=1 and c_req_* driven from the latch, stable until completion.
  - On c_resp_ready && c_resp_last: latch c_resp_data, go to RESP.
  - c_resp_ready with !c_resp_last is ignored; stay in BUSY.
- RESP:
  - The owner's data_ok=1 for one cycle; the non-owner's data_ok=0. Then go to IDLE.
  - No grant is issued in RESP.
- Response data:
  - i_resp_data = latched addr[2] ? resp[63:32] : resp[31:0].
  - d_resp_data = latched resp, unshifted.
  - Both hold their value until the next completion.
- Writes complete identically: data_ok is still pulsed, and the data value is don't-care.
- Master valid may drop after addr_ok without effect. A valid held during BUSY/RESP gets no addr_ok and waits.
- Minimum latency: addr_ok at T, c_req_valid at T+1, ready at T+1, data_ok at T+2. Back-to-back grants are possible at T+3.
- At most one addr_ok and one data_ok are asserted in any cycle.

Decomposition:
- Shared package (common): state enum arb_state_t {IDLE,BUSY,RESP}; owner enum; a cbus request struct bundling is_write/size/addr/strobe/data; constant MSIZE4=3'b010.
- One natural sub-module, arb_grant: pure combinational tie-break from (i_valid, d_valid, last_grant, ROUND_ROBIN) to a grant vector.
- FSM and latches stay in mem_bus_arbiter.

Test Plan:
- ibus only: i_req_valid=1, addr=0x8000_0004; ready at T+1 with data 0xDEAD_BEEF_0000_0013 -> addr_ok@T, c_req_size=2, c_req_addr=0x8000_0004, i_resp_data=0xDEADBEEF, data_ok@T+2.
- Simultaneous, ROUND_ROBIN=0: both valid -> dbus addr_ok first. ibus is granted in the IDLE after dbus data_ok, with no ibus addr_ok during BUSY/RESP.
- ROUND_ROBIN=1 with both valid continuously -> grants alternate D,I,D,I across 4 transactions.
- dbus write: strobe=0x0F, data=0x1122334455667788, addr=0x8000_1000 -> c_req_is_write=1, strobe 0x0F, fields stable for 3 stall cycles until ready&&last, then data_ok one cycle.
- Non-last beat: ready=1, last=0 at T+1, then ready=1, last=1 at T+3 -> stays BUSY; data_ok at T+4 carries the T+3 data.
- Reset asserted in BUSY -> next cycle c_req_valid=0, state IDLE. A ready pulse afterward produces no data_ok.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus to cbus arbiter: FSM states, owner tag and
// the latched cbus request bundle.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  localparam logic [2:0] MSIZE4 = 3'b010;

endpackage

// File: rtl/mem_bus_arbiter_grant.sv
// Combinational tie-break between ibus and dbus; grant[0] = ibus, grant[1] = dbus.
// Callers gate the valids so that no grant can appear outside IDLE.
module arb_grant
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (i_valid && d_valid) begin
      // Round-robin hands the tie to whichever master did not win last time.
      if ((ROUND_ROBIN != 0) && (last_grant == OWN_D)) grant = 2'b01;
      else                                             grant = 2'b10;
    end else begin
      grant = {d_valid, i_valid};
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the core's ibus and dbus onto a single-beat cbus, one outstanding
// transaction at a time, with addr_ok/data_ok handshakes back to the core.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN   = 0,
  parameter int RESET_GRANT_D = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [63:0] i_req_addr,
  output logic        i_resp_addr_ok,
  output logic        i_resp_data_ok,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  input  logic [63:0] d_req_addr,
  input  logic [2:0]  d_req_size,
  input  logic [7:0]  d_req_strobe,
  input  logic [63:0] d_req_data,
  output logic        d_resp_addr_ok,
  output logic        d_resp_data_ok,
  output logic [63:0] d_resp_data,
  output logic        c_req_valid,
  output logic        c_req_is_write,
  output logic [2:0]  c_req_size,
  output logic [63:0] c_req_addr,
  output logic [7:0]  c_req_strobe,
  output logic [63:0] c_req_data,
  input  logic        c_resp_ready,
  input  logic        c_resp_last,
  input  logic [63:0] c_resp_data
);

  localparam owner_t LAST_GRANT_INIT = (RESET_GRANT_D != 0) ? OWN_D : OWN_I;

  arb_state_t  state_reg;
  owner_t      owner_reg;
  owner_t      last_grant_reg;
  cbus_req_t   req_reg;
  cbus_req_t   req_next;
  logic        c_req_valid_reg;
  logic        i_data_ok_reg;
  logic        d_data_ok_reg;
  logic [31:0] i_resp_data_reg;
  logic [63:0] d_resp_data_reg;
  logic [1:0]  grant;
  logic        grant_en;

  assign grant_en = !reset && (state_reg == IDLE);

  arb_grant #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_grant (
    .i_valid   (i_req_valid && grant_en),
    .d_valid   (d_req_valid && grant_en),
    .last_grant(last_grant_reg),
    .grant     (grant)
  );

  always_comb begin
    req_next = '0;
    if (grant[1]) begin
      req_next.is_write = (d_req_strobe != 8'h00);
      req_next.size     = d_req_size;
      req_next.addr     = d_req_addr;
      req_next.strobe   = d_req_strobe;
      req_next.data     = d_req_data;
    end else begin
      req_next.size     = MSIZE4;
      req_next.addr     = i_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      owner_reg       <= OWN_I;
      last_grant_reg  <= LAST_GRANT_INIT;
      req_reg         <= '0;
      c_req_valid_reg <= 1'b0;
      i_data_ok_reg   <= 1'b0;
      d_data_ok_reg   <= 1'b0;
      i_resp_data_reg <= '0;
      d_resp_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant != 2'b00) begin
            req_reg         <= req_next;
            owner_reg       <= grant[1] ? OWN_D : OWN_I;
            last_grant_reg  <= grant[1] ? OWN_D : OWN_I;
            c_req_valid_reg <= 1'b1;
            state_reg       <= BUSY;
          end
        end
        BUSY: begin
          // Only the final beat completes; the fetch word is chosen now so it
          // survives the next grant overwriting the latched address.
          if (c_resp_ready && c_resp_last) begin
            i_resp_data_reg <= req_reg.addr[2] ? c_resp_data[63:32] : c_resp_data[31:0];
            d_resp_data_reg <= c_resp_data;
            c_req_valid_reg <= 1'b0;
            i_data_ok_reg   <= (owner_reg == OWN_I);
            d_data_ok_reg   <= (owner_reg == OWN_D);
            state_reg       <= RESP;
          end
        end
        RESP: begin
          i_data_ok_reg <= 1'b0;
          d_data_ok_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign i_resp_addr_ok = grant[0];
  assign d_resp_addr_ok = grant[1];
  assign i_resp_data_ok = i_data_ok_reg;
  assign d_resp_data_ok = d_data_ok_reg;
  assign i_resp_data    = i_resp_data_reg;
  assign d_resp_data    = d_resp_data_reg;
  assign c_req_valid    = c_req_valid_reg;
  assign c_req_is_write = req_reg.is_write;
  assign c_req_size     = req_reg.size;
  assign c_req_addr     = req_reg.addr;
  assign c_req_strobe   = req_reg.strobe;
  assign c_req_data     = req_reg.data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives a priority (inst 0) and a round-robin (inst 1) arbiter from the same
// stimulus and checks both against a transaction-level model every cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [63:0] i_req_addr = '0;
  logic        d_req_valid = 1'b0;
  logic [63:0] d_req_addr = '0;
  logic [2:0]  d_req_size = '0;
  logic [7:0]  d_req_strobe = '0;
  logic [63:0] d_req_data = '0;
  logic        c_resp_ready = 1'b0;
  logic        c_resp_last = 1'b0;
  logic [63:0] c_resp_data = '0;

  logic        i_aok [2];
  logic        i_dok [2];
  logic [31:0] i_rdat [2];
  logic        d_aok [2];
  logic        d_dok [2];
  logic [63:0] d_rdat [2];
  logic        c_val [2];
  logic        c_wr [2];
  logic [2:0]  c_size [2];
  logic [63:0] c_addr [2];
  logic [7:0]  c_strb [2];
  logic [63:0] c_wdat [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ROUND_ROBIN(0), .RESET_GRANT_D(1)) dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_addr_ok(i_aok[0]), .i_resp_data_ok(i_dok[0]), .i_resp_data(i_rdat[0]),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_size(d_req_size),
    .d_req_strobe(d_req_strobe), .d_req_data(d_req_data),
    .d_resp_addr_ok(d_aok[0]), .d_resp_data_ok(d_dok[0]), .d_resp_data(d_rdat[0]),
    .c_req_valid(c_val[0]), .c_req_is_write(c_wr[0]), .c_req_size(c_size[0]),
    .c_req_addr(c_addr[0]), .c_req_strobe(c_strb[0]), .c_req_data(c_wdat[0]),
    .c_resp_ready(c_resp_ready), .c_resp_last(c_resp_last), .c_resp_data(c_resp_data)
  );

  mem_bus_arbiter #(.ROUND_ROBIN(1), .RESET_GRANT_D(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_addr_ok(i_aok[1]), .i_resp_data_ok(i_dok[1]), .i_resp_data(i_rdat[1]),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_size(d_req_size),
    .d_req_strobe(d_req_strobe), .d_req_data(d_req_data),
    .d_resp_addr_ok(d_aok[1]), .d_resp_data_ok(d_dok[1]), .d_resp_data(d_rdat[1]),
    .c_req_valid(c_val[1]), .c_req_is_write(c_wr[1]), .c_req_size(c_size[1]),
    .c_req_addr(c_addr[1]), .c_req_strobe(c_strb[1]), .c_req_data(c_wdat[1]),
    .c_resp_ready(c_resp_ready), .c_resp_last(c_resp_last), .c_resp_data(c_resp_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each instance either waits for a request, has
  // one request outstanding on the cbus, or owes the owner its data_ok.
  bit          seen_reset = 1'b0;
  bit          m_pending [2];
  bit          m_owes [2];
  bit          m_own_d [2];
  bit          m_last_d [2];
  logic        m_wr [2];
  logic [2:0]  m_size [2];
  logic [63:0] m_addr [2];
  logic [7:0]  m_strb [2];
  logic [63:0] m_wdat [2];
  logic [31:0] m_idat [2];
  logic [63:0] m_ddat [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        chk($sformatf("rst_i_aok%0d", k), 64'(i_aok[k]), 64'd0);
        chk($sformatf("rst_d_aok%0d", k), 64'(d_aok[k]), 64'd0);
        m_pending[k] = 1'b0; m_owes[k] = 1'b0; m_own_d[k] = 1'b0; m_last_d[k] = 1'b1;
        m_wr[k] = 1'b0; m_size[k] = '0; m_addr[k] = '0; m_strb[k] = '0; m_wdat[k] = '0;
        m_idat[k] = '0; m_ddat[k] = '0;
      end else if (seen_reset) begin
        automatic bit free = !m_pending[k] && !m_owes[k];
        automatic bit gi = 1'b0;
        automatic bit gd = 1'b0;
        if (free) begin
          if (i_req_valid && d_req_valid) begin
            if (k == 1) begin gd = !m_last_d[k]; gi = m_last_d[k]; end
            else gd = 1'b1;
          end else begin
            gi = i_req_valid; gd = d_req_valid;
          end
        end
        chk($sformatf("i_aok%0d", k), 64'(i_aok[k]), 64'(gi));
        chk($sformatf("d_aok%0d", k), 64'(d_aok[k]), 64'(gd));
        chk($sformatf("c_val%0d", k), 64'(c_val[k]), 64'(m_pending[k]));
        chk($sformatf("c_wr%0d", k), 64'(c_wr[k]), 64'(m_wr[k]));
        chk($sformatf("c_size%0d", k), 64'(c_size[k]), 64'(m_size[k]));
        chk($sformatf("c_addr%0d", k), c_addr[k], m_addr[k]);
        chk($sformatf("c_strb%0d", k), 64'(c_strb[k]), 64'(m_strb[k]));
        chk($sformatf("c_wdat%0d", k), c_wdat[k], m_wdat[k]);
        chk($sformatf("i_dok%0d", k), 64'(i_dok[k]), 64'(m_owes[k] && !m_own_d[k]));
        chk($sformatf("d_dok%0d", k), 64'(d_dok[k]), 64'(m_owes[k] && m_own_d[k]));
        chk($sformatf("i_rdat%0d", k), 64'(i_rdat[k]), 64'(m_idat[k]));
        chk($sformatf("d_rdat%0d", k), d_rdat[k], m_ddat[k]);
        if (m_owes[k]) begin
          $display("[TB] inst%0d done %s addr=%h idata=%h ddata=%h", k,
                   m_own_d[k] ? "dbus" : "ibus", m_addr[k], m_idat[k], m_ddat[k]);
          m_owes[k] = 1'b0;
        end else if (m_pending[k]) begin
          if (c_resp_ready && c_resp_last) begin
            m_ddat[k] = c_resp_data;
            m_idat[k] = m_addr[k][2] ? c_resp_data[63:32] : c_resp_data[31:0];
            m_pending[k] = 1'b0;
            m_owes[k] = 1'b1;
          end
        end else if (gd) begin
          m_pending[k] = 1'b1; m_own_d[k] = 1'b1; m_last_d[k] = 1'b1;
          m_wr[k] = (d_req_strobe != 0); m_size[k] = d_req_size; m_addr[k] = d_req_addr;
          m_strb[k] = d_req_strobe; m_wdat[k] = d_req_data;
        end else if (gi) begin
          m_pending[k] = 1'b1; m_own_d[k] = 1'b0; m_last_d[k] = 1'b0;
          m_wr[k] = 1'b0; m_size[k] = 3'b010; m_addr[k] = i_req_addr;
          m_strb[k] = '0; m_wdat[k] = '0;
        end
      end
    end
    if (reset) seen_reset = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #2;
  endtask

  bit q0 [$];
  bit q1 [$];

  initial begin
    tick; tick;
    reset = 1'b0;
    settle;
    chk("reset_c_val", 64'(c_val[0]), 64'd0);
    chk("reset_c_addr", c_addr[0], 64'd0);
    chk("reset_i_rdat", 64'(i_rdat[0]), 64'd0);
    chk("reset_d_rdat", d_rdat[1], 64'd0);

    // ibus-only fetch with minimum latency
    tick;
    i_req_valid = 1'b1; i_req_addr = 64'h8000_0004;
    settle;
    chk("ionly_i_aok", 64'(i_aok[0]), 64'd1);
    chk("ionly_d_aok", 64'(d_aok[0]), 64'd0);
    tick;
    i_req_valid = 1'b0; c_resp_ready = 1'b1; c_resp_last = 1'b1;
    c_resp_data = 64'hDEAD_BEEF_0000_0013;
    settle;
    chk("ionly_c_val", 64'(c_val[0]), 64'd1);
    chk("ionly_c_size", 64'(c_size[0]), 64'd2);
    chk("ionly_c_addr", c_addr[0], 64'h8000_0004);
    tick;
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    settle;
    chk("ionly_i_dok", 64'(i_dok[0]), 64'd1);
    chk("ionly_i_rdat", 64'(i_rdat[0]), 64'hDEADBEEF);
    tick;

    // simultaneous requests, priority instance takes dbus first
    i_req_valid = 1'b1; i_req_addr = 64'h8000_0020;
    d_req_valid = 1'b1; d_req_addr = 64'h8000_0100; d_req_size = 3'd3;
    d_req_strobe = 8'h00; d_req_data = '0;
    settle;
    chk("both_d_aok", 64'(d_aok[0]), 64'd1);
    chk("both_i_aok", 64'(i_aok[0]), 64'd0);
    tick;
    d_req_valid = 1'b0; c_resp_ready = 1'b1; c_resp_last = 1'b1;
    settle;
    chk("both_busy_i_aok", 64'(i_aok[0]), 64'd0);
    tick;
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    settle;
    chk("both_d_dok", 64'(d_dok[0]), 64'd1);
    chk("both_resp_i_aok", 64'(i_aok[0]), 64'd0);
    tick;
    settle;
    chk("both_late_i_aok", 64'(i_aok[0]), 64'd1);
    tick;
    i_req_valid = 1'b0; c_resp_ready = 1'b1; c_resp_last = 1'b1;
    tick;
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    tick;

    // continuous contention: round-robin alternates, priority stays on dbus
    i_req_valid = 1'b1; d_req_valid = 1'b1; c_resp_ready = 1'b1; c_resp_last = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle;
      if (d_aok[1]) q1.push_back(1'b1);
      if (i_aok[1]) q1.push_back(1'b0);
      if (d_aok[0]) q0.push_back(1'b1);
      if (i_aok[0]) q0.push_back(1'b0);
      tick;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0; c_resp_ready = 1'b0; c_resp_last = 1'b0;
    chk("rr_count", 64'(q1.size()), 64'd4);
    chk("prio_count", 64'(q0.size()), 64'd4);
    for (int n = 0; n < 4 && n < q1.size() && n < q0.size(); n++) begin
      chk($sformatf("rr_order%0d", n), 64'(q1[n]), 64'((n % 2) == 0));
      chk($sformatf("prio_order%0d", n), 64'(q0[n]), 64'd1);
    end

    // dbus write stalled three cycles
    d_req_valid = 1'b1; d_req_addr = 64'h8000_1000; d_req_size = 3'd3;
    d_req_strobe = 8'h0F; d_req_data = 64'h1122334455667788;
    settle;
    chk("wr_d_aok", 64'(d_aok[0]), 64'd1);
    tick;
    d_req_valid = 1'b0; d_req_strobe = 8'h00; d_req_data = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin c_resp_ready = 1'b1; c_resp_last = 1'b1; end
      settle;
      chk("wr_c_val", 64'(c_val[0]), 64'd1);
      chk("wr_c_wr", 64'(c_wr[0]), 64'd1);
      chk("wr_c_strb", 64'(c_strb[0]), 64'h0F);
      chk("wr_c_addr", c_addr[0], 64'h8000_1000);
      chk("wr_c_wdat", c_wdat[0], 64'h1122334455667788);
      chk("wr_stall_dok", 64'(d_dok[0]), 64'd0);
      tick;
    end
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    settle;
    chk("wr_d_dok", 64'(d_dok[0]), 64'd1);
    tick;
    settle;
    chk("wr_d_dok_once", 64'(d_dok[0]), 64'd0);
    tick;

    // non-last beat is ignored, last beat data is returned
    d_req_valid = 1'b1; d_req_addr = 64'h8000_2008; d_req_size = 3'd3;
    tick;
    d_req_valid = 1'b0; c_resp_ready = 1'b1; c_resp_last = 1'b0;
    c_resp_data = 64'hAAAA_AAAA_AAAA_AAAA;
    tick;
    c_resp_ready = 1'b0;
    settle;
    chk("nl_c_val", 64'(c_val[0]), 64'd1);
    chk("nl_dok_early", 64'(d_dok[0]), 64'd0);
    tick;
    c_resp_ready = 1'b1; c_resp_last = 1'b1; c_resp_data = 64'h0123_4567_89AB_CDEF;
    tick;
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    settle;
    chk("nl_d_dok", 64'(d_dok[0]), 64'd1);
    chk("nl_d_rdat", d_rdat[0], 64'h0123_4567_89AB_CDEF);
    tick;

    // reset in the middle of a transaction
    i_req_valid = 1'b1; i_req_addr = 64'h8000_0010;
    tick;
    i_req_valid = 1'b0; reset = 1'b1;
    settle;
    chk("mid_busy_c_val", 64'(c_val[0]), 64'd1);
    tick;
    reset = 1'b0;
    settle;
    chk("mid_rst_c_val", 64'(c_val[0]), 64'd0);
    c_resp_ready = 1'b1; c_resp_last = 1'b1;
    tick;
    c_resp_ready = 1'b0; c_resp_last = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle;
      chk("mid_rst_i_dok", 64'(i_dok[0]), 64'd0);
      chk("mid_rst_d_dok", 64'(d_dok[0]), 64'd0);
      tick;
    end

    // randomized traffic, checked by the model
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(63) == 0);
      i_req_valid  = $urandom_range(1);
      i_req_addr   = {$urandom, $urandom & 32'hFFFF_FFFC};
      d_req_valid  = $urandom_range(1);
      d_req_addr   = {$urandom, $urandom};
      d_req_size   = 3'($urandom_range(3));
      d_req_strobe = $urandom_range(1) ? 8'($urandom) : 8'h00;
      d_req_data   = {$urandom, $urandom};
      c_resp_ready = $urandom_range(1);
      c_resp_last  = $urandom_range(1);
      c_resp_data  = {$urandom, $urandom};
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
